// File: rtl/xnort_seqq.sv
// xnort_seqq: bit-serial XNOR neuron bank.
// Each enabled cycle takes one input bit, data[idx]. Every neuron whose
// weight for that input is unmasked adds 1 when the bit agrees with the
// weight sign. After N steps, each sums slice holds that neuron's XNOR
// popcount. The result then stays frozen until reset.
// Optional build macro: XNORT_SEQQ_SAT_EN. When it is defined, each
// accumulator saturates at 2^B-1. When it is not defined, each
// accumulator wraps modulo 2^B.
module xnort_seqq #(
   parameter int N = 4,
   parameter int M = 4,
   parameter int B = 4,
   parameter logic [N*M-1:0] W_MASK = '1,
   parameter logic [N*M-1:0] W_SIGN = '1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   data,
   input  logic           enable,
   output logic [B*M-1:0] sums,
   output logic           done
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   logic [IW-1:0] r_idx;
   logic          r_done;
   logic          w_step;
   logic          w_data_bit;

   // A step happens only while enabled and before the last input is consumed.
   assign w_step     = enable & ~r_done;
   assign w_data_bit = data[r_idx];
   assign done       = r_done;

   // Step index and completion flag: idx freezes on the final step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx  <= '0;
         r_done <= 1'b0;
      end else if (w_step) begin
         if (r_idx == LAST_IDX) begin
            r_done <= 1'b1;
         end else begin
            r_idx <= r_idx + IW'(1);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < M; gi = gi + 1) begin : g_neuron
         localparam logic [N-1:0] MASK_ROW = W_MASK[gi*N +: N];
         localparam logic [N-1:0] SIGN_ROW = W_SIGN[gi*N +: N];

         logic [B-1:0] r_acc;
         logic         w_term;
         logic [B-1:0] w_acc_next;

         // A masked-out weight contributes nothing, whatever the data bit is.
         assign w_term = MASK_ROW[r_idx] & ~(w_data_bit ^ SIGN_ROW[r_idx]);

`ifdef XNORT_SEQQ_SAT_EN
         assign w_acc_next = (&r_acc) ? r_acc : (r_acc + B'(w_term));
`else
         assign w_acc_next = r_acc + B'(w_term);
`endif

         // Accumulator: advances only on a real step and holds on a stall or after done.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_acc <= '0;
            end else if (w_step) begin
               r_acc <= w_acc_next;
            end
         end

         assign sums[B*gi +: B] = r_acc;
      end
   endgenerate

endmodule

// File: tb/tb_xnort_seqq.sv
// Directed testbench for xnort_seqq.
// It instantiates four configurations: the defaults, W_SIGN=16'h00FF,
// a mixed mask, and a wide N=20/M=1 build that exercises wrap or
// saturation.
module tb_xnort_seqq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [3:0]  data_def = 4'hF;
   logic [3:0]  data_sgn = 4'b0011;
   logic [3:0]  data_msk = 4'b1011;
   logic [19:0] data_big = '1;

   logic [15:0] sums_def, sums_sgn, sums_msk;
   logic [3:0]  sums_big;
   logic        done_def, done_sgn, done_msk, done_big;

   int n_cmp = 0;
   int n_mis = 0;

`ifdef XNORT_SEQQ_SAT_EN
   localparam logic [3:0] BIG_EXP = 4'hF;
`else
   localparam logic [3:0] BIG_EXP = 4'h4;
`endif

   always #5 clk = ~clk;

   xnort_seqq u_def (
      .clk(clk), .rst(rst), .data(data_def), .enable(enable),
      .sums(sums_def), .done(done_def)
   );

   xnort_seqq #(.W_SIGN(16'h00FF)) u_sgn (
      .clk(clk), .rst(rst), .data(data_sgn), .enable(enable),
      .sums(sums_sgn), .done(done_sgn)
   );

   xnort_seqq #(.W_MASK(16'h0F31)) u_msk (
      .clk(clk), .rst(rst), .data(data_msk), .enable(enable),
      .sums(sums_msk), .done(done_msk)
   );

   xnort_seqq #(.N(20), .M(1), .B(4)) u_big (
      .clk(clk), .rst(rst), .data(data_big), .enable(enable),
      .sums(sums_big), .done(done_big)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("t=%0t %-14s observed=%0h expected=%0h", $time, tag, obs, exp);
   endtask

   // Wait for a rising edge, then settle 1 time unit before sampling or driving.
   task automatic edges(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pulse reset low between edges, then release with enable high.
   task automatic restart();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      enable = 1'b1;
   endtask

   initial begin
      // Reset state.
      #3;
      chk("rst_sums", 32'(sums_def), 32'h0);
      chk("rst_done", 32'(done_def), 32'h0);
      edges(2);
      chk("rst_hold", 32'(sums_def), 32'h0);
      rst = 1'b1;
      enable = 1'b1;

      // Baseline run: all-ones data, plus the sign and mask variants.
      edges(2);
      chk("partial_sums", 32'(sums_def), 32'h2222);
      chk("partial_done", 32'(done_def), 32'h0);
      edges(2);
      chk("base_sums", 32'(sums_def), 32'h4444);
      chk("base_done", 32'(done_def), 32'h1);
      chk("sign_sums", 32'(sums_sgn), 32'h2222);
      chk("sign_done", 32'(done_sgn), 32'h1);
      chk("mask_sums", 32'(sums_msk), 32'h0321);

      // After done, the result ignores later data and enable.
      data_def = 4'h0;
      edges(10);
      chk("hold_sums", 32'(sums_def), 32'h4444);
      chk("hold_done", 32'(done_def), 32'h1);

      // Wide instance: 20 steps into a 4-bit sum.
      edges(5);
      chk("big_done19", 32'(done_big), 32'h0);
      edges(1);
      chk("big_sums", 32'(sums_big), 32'(BIG_EXP));
      chk("big_done", 32'(done_big), 32'h1);

      // All-zero data gives zero sums.
      restart();
      edges(3);
      chk("zero_done3", 32'(done_def), 32'h0);
      edges(1);
      chk("zero_sums", 32'(sums_def), 32'h0);
      chk("zero_done", 32'(done_def), 32'h1);

      // Stall for 2 cycles after step 2.
      data_def = 4'hF;
      restart();
      edges(2);
      enable = 1'b0;
      edges(2);
      chk("stall_sums", 32'(sums_def), 32'h2222);
      chk("stall_done", 32'(done_def), 32'h0);
      enable = 1'b1;
      edges(1);
      chk("stall_step3", 32'(sums_def), 32'h3333);
      chk("stall_done3", 32'(done_def), 32'h0);
      edges(1);
      chk("stall_final", 32'(sums_def), 32'h4444);
      chk("stall_donef", 32'(done_def), 32'h1);

      // Reset mid-run clears the state at once, then the run restarts cleanly.
      restart();
      edges(2);
      chk("abort_pre", 32'(sums_def), 32'h2222);
      rst = 1'b0;
      #1;
      chk("abort_sums", 32'(sums_def), 32'h0);
      chk("abort_done", 32'(done_def), 32'h0);
      #1;
      rst = 1'b1;
      edges(3);
      chk("abort_step3", 32'(done_def), 32'h0);
      edges(1);
      chk("abort_final", 32'(sums_def), 32'h4444);
      chk("abort_donef", 32'(done_def), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/xnort_seqq.md
XNORT_SEQQ -- requirements
Module: xnort_seqq

Interface
REQ-001 SHALL have parameter N, default 4: number of input bits, processed one per cycle.
REQ-002 SHALL have parameter M, default 4: number of neurons (accumulators).
REQ-003 SHALL have parameter B, default 4: width of each neuron sum.
REQ-004 SHALL have parameter W_MASK [N*M-1:0], default all ones: weight nonzero flags; bit j*N+i is neuron j, input i.
REQ-005 SHALL have parameter W_SIGN [N*M-1:0], default all ones: weight signs (1 = +1, 0 = -1); same layout as W_MASK.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port data, input, N bits: input activation vector, held stable for the whole run.
REQ-009 SHALL have port enable, input, 1 bit: advance one step per cycle while high.
REQ-010 SHALL have port sums, output, B*M bits: neuron j occupies sums[B*j+B-1:B*j].
REQ-011 SHALL have port done, output, 1 bit: high once all N inputs are accumulated.

Function
REQ-012 SHALL contain a step index idx (0..N-1), per-neuron accumulators acc[j] of B bits, and a done flag; sums SHALL be driven directly from acc.
REQ-013 SHALL, on each rising edge with enable=1 and done=0, add term(j,idx) to every acc[j] in parallel, where term = W_MASK[j*N+idx] AND XNOR(data[idx], W_SIGN[j*N+idx]).
REQ-014 SHALL contribute zero for a masked-out weight (mask=0) regardless of data.
REQ-015 SHALL increment idx after each step; at the step where idx=N-1, set done=1 on that same edge and freeze idx.
REQ-016 SHALL make sums final, with done=1, exactly N enabled edges after reset release.
REQ-017 SHALL hold idx and acc unchanged on any edge with enable=0 (stall); no step is lost or repeated.
REQ-018 SHALL, once done=1, hold acc, sums and done stable until reset, regardless of enable or data.
REQ-019 SHALL show partial sums on the sums port during a run.
REQ-020 SHALL produce a final value for each neuron that equals the popcount of its XNOR matches over the unmasked inputs.

Reset
REQ-021 SHALL, while rst=0, asynchronously clear idx, all acc and done; sums SHALL read 0 and done SHALL read 0.
REQ-022 SHALL, if reset is asserted mid-run, abort the run; after release the run SHALL restart from idx=0 with zero sums.
REQ-023 SHALL take its first step on the first rising edge where rst=1 and enable=1.

Configuration
REQ-024 SHALL, when macro XNORT_SEQQ_SAT_EN is defined, saturate each acc[j] at 2^B-1, with further increments ignored.
REQ-025 SHALL, when XNORT_SEQQ_SAT_EN is undefined, let acc[j] wrap modulo 2^B.
REQ-026 SHALL produce identical results in both configurations when B >= ceil(log2(N+1)); the defaults satisfy this.

Verification
REQ-027 SHALL cover: defaults, data=4'hF, enable=1, release reset, 4 edges -> sums=16'h4444, done=1; sums unchanged 10 cycles later.
REQ-028 SHALL cover: defaults, data=4'h0 -> after 4 edges sums=16'h0000, done=1.
REQ-029 SHALL cover: W_SIGN=16'h00FF (neurons 0,1 sign +1; neurons 2,3 sign -1), data=4'b0011 -> sums=16'h2222.
REQ-030 SHALL cover: defaults, data=4'hF, enable low for 2 cycles after step 2 -> done asserted 2 cycles later than baseline; sums=16'h4444.
REQ-031 SHALL cover: rst pulsed low after step 2 -> sums=0 and done=0 immediately (no clock edge); after release and 4 more edges sums=16'h4444.
REQ-032 SHALL cover: N=20, B=4, M=1, all-ones weights and data -> sums=4'hF with XNORT_SEQQ_SAT_EN defined; 4'h4 without it.
